uart_rx: RTL
============

UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 SHALL have parameter CLK_PER_BIT, default 5208; clock cycles per bit (clk frequency / baud rate); legal range 4..65535.
REQ-002 SHALL have port clk  input  1  single system clock; all state on rising edge.
REQ-003 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port rx  input  1  serial line, idle high, asynchronous to clk.
REQ-005 SHALL have port data_out  output  8  last received byte, LSB first on the line.
REQ-006 SHALL have port valid  output  1  one-cycle pulse: data_out holds a new, correctly framed byte.
REQ-007 SHALL have port framing_error  output  1  one-cycle pulse: stop bit sampled low.
REQ-008 SHALL have port busy  output  1  high whenever the FSM is not in IDLE.

Function
REQ-009 SHALL pass rx through a 2-flop synchronizer; all logic uses the synchronized rx_s only (2-cycle input latency).
REQ-010 SHALL implement FSM states IDLE, START, DATA, STOP, BREAK_WAIT with a 16-bit clk_count and 3-bit bit index.
REQ-011 IDLE: clk_count=0, index=0; rx_s==0 -> START.
REQ-012 START: count to CLK_PER_BIT/2-1 (floor), then re-sample rx_s; 0 -> clk_count=0, DATA; 1 -> glitch, IDLE, no pulse.
REQ-013 DATA: sample rx_s into shift position [index] when clk_count==CLK_PER_BIT-1 (mid-bit), clk_count=0; after index 7 -> STOP, else index+1.
REQ-014 STOP: sample rx_s at clk_count==CLK_PER_BIT-1; 1 -> data_out=shift reg, valid=1 next cycle, IDLE; 0 -> framing_error=1 next cycle, data_out unchanged, BREAK_WAIT.
REQ-015 BREAK_WAIT: stay until rx_s==1, then IDLE; no pulses while waiting.
REQ-016 valid and framing_error SHALL be exactly one cycle wide and never high together.
REQ-017 data_out SHALL change only in the cycle valid rises and hold otherwise.
REQ-018 Back-to-back frames: a start edge seen in the first IDLE cycle after STOP SHALL be received with no lost byte.
REQ-019 Frame start (rx falling edge) to valid SHALL be 2 + CLK_PER_BIT/2 + 9*CLK_PER_BIT + 1 cycles ±1.
REQ-020 Undefined state encodings SHALL return to IDLE next cycle with counters cleared.

Reset
REQ-021 rst_n low SHALL immediately force IDLE, clk_count=0, index=0, shift reg=0, data_out=8'h00, valid=0, framing_error=0, busy=0, synchronizer flops=1.
REQ-022 Reset asserted mid-frame SHALL discard the partial byte; after release, reception restarts only on a new falling edge of rx_s.

Structure
REQ-023 State encodings and default CLK_PER_BIT SHALL live in a shared uart package used by both uart_rx and the transmitter.
REQ-024 The 2-flop synchronizer SHALL be a separate sub-module sync_2ff (reset value 1, parameterizable).
REQ-025 Implementation SHALL be a single clocked FSM process plus sync_2ff instance; no clock dividers or derived clocks.

Verification (CLK_PER_BIT=16 in benches)
REQ-026 Send 8'hA5 (start,1,0,1,0,0,1,0,1,stop) -> one valid pulse, data_out=8'hA5, framing_error=0, latency per REQ-019.
REQ-027 rx low 5 cycles then high (glitch) -> FSM back to IDLE, no valid, no framing_error, data_out unchanged.
REQ-028 Send 8'h3C with stop bit held low 40 cycles -> one framing_error pulse, no valid, data_out unchanged, busy until rx high, then IDLE.
REQ-029 Back-to-back 8'h00, 8'hFF, 8'h55 with no idle gap -> three valid pulses, bytes in order.
REQ-030 Assert rst_n low during bit 4 of 8'h81, release, send 8'h7E -> all outputs reset values, only 8'h7E reported.
REQ-031 Loopback with the transmitter at CLK_PER_BIT=16 and receiver at 15 and 17 -> 8'hC3 received correctly in both cases.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions used by both the receiver and the transmitter:
// FSM state encodings and the default clocks-per-bit setting.
package uart_pkg;

    localparam int CLK_PER_BIT_DEFAULT = 5208;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_START      = 3'd1,
        ST_DATA       = 3'd2,
        ST_STOP       = 3'd3,
        ST_BREAK_WAIT = 3'd4
    } uart_state_t;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for bringing asynchronous inputs into the clk domain.
// The reset value is a parameter so idle-high lines do not fake an edge.
module sync_2ff #(
    parameter int               WIDTH     = 1,
    parameter logic [WIDTH-1:0] RESET_VAL = '1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] r_meta;
    logic [WIDTH-1:0] r_sync;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_meta <= RESET_VAL;
            r_sync <= RESET_VAL;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: synchronizes rx, finds the start-bit centre, then samples
// each following bit one bit-time apart and reports valid or framing_error.
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLK_PER_BIT = CLK_PER_BIT_DEFAULT
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx,
    output logic [7:0] data_out,
    output logic       valid,
    output logic       framing_error,
    output logic       busy
);

    localparam logic [15:0] HALF_LAST = 16'(CLK_PER_BIT / 2 - 1);
    localparam logic [15:0] FULL_LAST = 16'(CLK_PER_BIT - 1);

    logic        w_rx_s;

    uart_state_t r_state;
    logic [15:0] r_count;
    logic [2:0]  r_index;
    logic [7:0]  r_shift;
    logic [7:0]  r_data;
    logic        r_valid;
    logic        r_ferr;

    uart_state_t w_state_next;
    logic [15:0] w_count_next;
    logic [2:0]  w_index_next;
    logic [7:0]  w_shift_next;
    logic [7:0]  w_data_next;
    logic        w_valid_next;
    logic        w_ferr_next;

    sync_2ff #(
        .WIDTH    (1),
        .RESET_VAL(1'b1)
    ) u_sync (
        .clk  (clk),
        .rst_n(rst_n),
        .i_d  (rx),
        .o_q  (w_rx_s)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_count <= 16'd0;
            r_index <= 3'd0;
            r_shift <= 8'h00;
            r_data  <= 8'h00;
            r_valid <= 1'b0;
            r_ferr  <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_count <= w_count_next;
            r_index <= w_index_next;
            r_shift <= w_shift_next;
            r_data  <= w_data_next;
            r_valid <= w_valid_next;
            r_ferr  <= w_ferr_next;
        end
    end

    // Pulses default low every cycle, so each one lasts exactly one clock.
    always_comb begin
        w_state_next = r_state;
        w_count_next = r_count;
        w_index_next = r_index;
        w_shift_next = r_shift;
        w_data_next  = r_data;
        w_valid_next = 1'b0;
        w_ferr_next  = 1'b0;

        case (r_state)
            ST_IDLE: begin
                w_count_next = 16'd0;
                w_index_next = 3'd0;
                if (!w_rx_s) begin
                    w_state_next = ST_START;
                end
            end
            ST_START: begin
                if (r_count == HALF_LAST) begin
                    w_count_next = 16'd0;
                    w_state_next = w_rx_s ? ST_IDLE : ST_DATA;
                end else begin
                    w_count_next = r_count + 16'd1;
                end
            end
            ST_DATA: begin
                if (r_count == FULL_LAST) begin
                    w_count_next          = 16'd0;
                    w_shift_next[r_index] = w_rx_s;
                    if (r_index == 3'd7) begin
                        w_index_next = 3'd0;
                        w_state_next = ST_STOP;
                    end else begin
                        w_index_next = r_index + 3'd1;
                    end
                end else begin
                    w_count_next = r_count + 16'd1;
                end
            end
            ST_STOP: begin
                if (r_count == FULL_LAST) begin
                    w_count_next = 16'd0;
                    if (w_rx_s) begin
                        w_data_next  = r_shift;
                        w_valid_next = 1'b1;
                        w_state_next = ST_IDLE;
                    end else begin
                        w_ferr_next  = 1'b1;
                        w_state_next = ST_BREAK_WAIT;
                    end
                end else begin
                    w_count_next = r_count + 16'd1;
                end
            end
            ST_BREAK_WAIT: begin
                w_count_next = 16'd0;
                if (w_rx_s) begin
                    w_state_next = ST_IDLE;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
                w_count_next = 16'd0;
                w_index_next = 3'd0;
            end
        endcase
    end

    assign data_out      = r_data;
    assign valid         = r_valid;
    assign framing_error = r_ferr;
    assign busy          = (r_state != ST_IDLE);

endmodule
